// File: rtl/bit_counter_arbiter.sv
// Round-robin sequencer sharing one external bit_counter among N_REQ requesters.
// Optional early stop on counter saturation: define BIT_COUNTER_ARB_EARLY_STOP_EN.
module bit_counter_arbiter #(
    parameter int N_REQ = 2,
    parameter int W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [1:0]         result,
    output logic               result_z,
    output logic               busy,
    output logic               cnt_x,
    output logic               cnt_rst,
    input  logic [1:0]         cnt_out,
    input  logic               cnt_z
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] ptr;
    logic [W-1:0]     shreg;
    logic [IDX_W-1:0] idx;
    logic             cnt_x_q;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [W-1:0]     win_word;
    logic             early_stop;
    logic             shift_last;

    // Requester index base+step, wrapped into 0..N_REQ-1.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return PTR_W'(sum);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] sel);
        logic [N_REQ-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // Scan upward from the round-robin pointer; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && req[wrap_inc(ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_inc(ptr, k);
            end
        end
    end

    always_comb begin
        win_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_word = data[i*W +: W];
            end
        end
    end

`ifdef BIT_COUNTER_ARB_EARLY_STOP_EN
    assign early_stop = cnt_z;
`else
    assign early_stop = 1'b0;
`endif

    assign shift_last = (idx == IDX_W'(W - 1)) || early_stop;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (win_found) state_next = S_CLEAR;
            S_CLEAR:   state_next = S_SHIFT;
            S_SHIFT:   if (shift_last) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && win_found) begin
                grant <= onehot(win_idx);
                ptr   <= wrap_inc(win_idx, 1);
            end else if (state == S_DONE) begin
                grant <= '0;
            end
        end
    end

    // cnt_x is loaded one cycle ahead, so shreg already holds the next bit at bit 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg    <= '0;
            idx      <= '0;
            cnt_x_q  <= 1'b0;
            result   <= '0;
            result_z <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_x_q <= 1'b0;
                    idx     <= '0;
                    if (win_found) begin
                        shreg <= win_word;
                    end
                end
                S_CLEAR: begin
                    cnt_x_q <= shreg[0];
                    shreg   <= shreg >> 1;
                    idx     <= '0;
                end
                S_SHIFT: begin
                    if (shift_last) begin
                        cnt_x_q <= 1'b0;
                    end else begin
                        cnt_x_q <= shreg[0];
                        shreg   <= shreg >> 1;
                        idx     <= idx + IDX_W'(1);
                    end
                end
                S_CAPTURE: begin
                    cnt_x_q  <= 1'b0;
                    result   <= cnt_out;
                    result_z <= cnt_z;
                end
                default: begin
                    cnt_x_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BIT_COUNTER_ARB_EARLY_STOP_EN
    // Suppress the pending bit in the cycle the counter reports saturation.
    assign cnt_x = cnt_x_q && !(state == S_SHIFT && cnt_z);
`else
    assign cnt_x = cnt_x_q;
`endif

    assign done    = (state == S_DONE) ? grant : '0;
    assign busy    = (state != S_IDLE);
    assign cnt_rst = rst && (state != S_CLEAR);

endmodule

// File: tb/tb_bit_counter_arbiter.sv
// Bench for bit_counter_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_bit_counter_arbiter;

    localparam int N  = 2;
    localparam int W  = 4;
    localparam int W8 = 8;
`ifdef BIT_COUNTER_ARB_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, W=4
    logic           rst;
    logic [N-1:0]   req;
    logic [3:0]     d0, d1;
    logic [N*W-1:0] data;
    logic [N-1:0]   grant, done;
    logic [1:0]     result;
    logic           result_z, busy, cnt_x, cnt_rst;
    logic [1:0]     cnt_out;
    logic           cnt_z;
    logic [1:0]     cnt;

    assign data    = {d1, d0};
    assign cnt_out = cnt;
    assign cnt_z   = (cnt == 2'd3);
    always @(posedge clk) begin
        if (!cnt_rst) cnt <= 2'd0;
        else          cnt <= cnt + {1'b0, cnt_x};
    end

    bit_counter_arbiter #(.N_REQ(N), .W(W)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .grant(grant), .done(done), .result(result), .result_z(result_z),
        .busy(busy), .cnt_x(cnt_x), .cnt_rst(cnt_rst),
        .cnt_out(cnt_out), .cnt_z(cnt_z)
    );

    // Second instance, W=8
    logic            rst8;
    logic [N-1:0]    req8;
    logic [7:0]      d8;
    logic [N*W8-1:0] data8;
    logic [N-1:0]    grant8, done8;
    logic [1:0]      result8;
    logic            result_z8, busy8, cnt_x8, cnt_rst8;
    logic [1:0]      cnt_out8;
    logic            cnt_z8;
    logic [1:0]      cnt8;

    assign data8    = {8'h00, d8};
    assign cnt_out8 = cnt8;
    assign cnt_z8   = (cnt8 == 2'd3);
    always @(posedge clk) begin
        if (!cnt_rst8) cnt8 <= 2'd0;
        else           cnt8 <= cnt8 + {1'b0, cnt_x8};
    end

    bit_counter_arbiter #(.N_REQ(N), .W(W8)) u_dut8 (
        .clk(clk), .rst(rst8), .req(req8), .data(data8),
        .grant(grant8), .done(done8), .result(result8), .result_z(result_z8),
        .busy(busy8), .cnt_x(cnt_x8), .cnt_rst(cnt_rst8),
        .cnt_out(cnt_out8), .cnt_z(cnt_z8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done == '0 && n < 40);
        if (done == '0) chk("done_timeout", 32'(n), 32'(0));
    endtask

    // Reference model: word value semantics only.
    function automatic int exp_result(input logic [7:0] w);
        int p;
        p = $countones(w);
        if (EARLY) return (p >= 3) ? 3 : p;
        return p % 4;
    endfunction

    function automatic int exp_shift(input logic [7:0] w, input int wid);
        int seen;
        seen = 0;
        if (!EARLY) return wid;
        for (int j = 0; j < wid; j++) begin
            if (w[j]) seen++;
            if (seen == 3) return (j < wid - 1) ? j + 2 : wid;
        end
        return wid;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // expected = {grant[2], done[2], busy, cnt_x, cnt_rst, result[2], result_z}
    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [1:0] q, input logic [3:0] a,
                                input logic [3:0] b, input logic [9:0] e);
        vec_t v;
        v.rst = r; v.req = q; v.d0 = a; v.d1 = b; v.exp = e;
        return v;
    endfunction

    vec_t vecs[29];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, owner, elen, m_ptr, nidle;
        logic [3:0] xs, w;
        logic [1:0] mask;
        bit drop;

        rst = 1'b0; req = '0; d0 = '0; d1 = '0;
        rst8 = 1'b0; req8 = '0; d8 = '0;

        vecs[0]  = mk(0, 2'b11, 4'hB, 4'h0, 10'b00_00_0_0_0_00_0);
        vecs[1]  = mk(0, 2'b11, 4'hB, 4'h0, 10'b00_00_0_0_0_00_0);
        vecs[2]  = mk(0, 2'b11, 4'hB, 4'h0, 10'b00_00_0_0_0_00_0);
        vecs[3]  = mk(1, 2'b00, 4'hB, 4'h0, 10'b00_00_0_0_1_00_0);
        vecs[4]  = mk(1, 2'b01, 4'hB, 4'h0, 10'b01_00_1_0_0_00_0);
        vecs[5]  = mk(1, 2'b01, 4'hB, 4'h0, 10'b01_00_1_1_1_00_0);
        vecs[6]  = mk(1, 2'b01, 4'hB, 4'h0, 10'b01_00_1_1_1_00_0);
        vecs[7]  = mk(1, 2'b01, 4'hB, 4'h0, 10'b01_00_1_0_1_00_0);
        vecs[8]  = mk(1, 2'b01, 4'hB, 4'h0, 10'b01_00_1_1_1_00_0);
        vecs[9]  = mk(1, 2'b00, 4'hB, 4'h0, 10'b01_00_1_0_1_00_0);
        vecs[10] = mk(1, 2'b00, 4'hB, 4'h0, 10'b01_01_1_0_1_11_1);
        vecs[11] = mk(1, 2'b00, 4'hB, 4'h0, 10'b00_00_0_0_1_11_1);
        vecs[12] = mk(0, 2'b00, 4'h1, 4'h3, 10'b00_00_0_0_0_00_0);
        vecs[13] = mk(1, 2'b11, 4'h1, 4'h3, 10'b01_00_1_0_0_00_0);
        vecs[14] = mk(1, 2'b11, 4'h1, 4'h3, 10'b01_00_1_1_1_00_0);
        vecs[15] = mk(1, 2'b11, 4'h1, 4'h3, 10'b01_00_1_0_1_00_0);
        vecs[16] = mk(1, 2'b11, 4'h1, 4'h3, 10'b01_00_1_0_1_00_0);
        vecs[17] = mk(1, 2'b11, 4'h1, 4'h3, 10'b01_00_1_0_1_00_0);
        vecs[18] = mk(1, 2'b11, 4'h1, 4'h3, 10'b01_00_1_0_1_00_0);
        vecs[19] = mk(1, 2'b11, 4'h1, 4'h3, 10'b01_01_1_0_1_01_0);
        vecs[20] = mk(1, 2'b11, 4'h1, 4'h3, 10'b00_00_0_0_1_01_0);
        vecs[21] = mk(1, 2'b11, 4'h1, 4'h3, 10'b10_00_1_0_0_01_0);
        vecs[22] = mk(1, 2'b11, 4'h1, 4'h3, 10'b10_00_1_1_1_01_0);
        vecs[23] = mk(1, 2'b11, 4'h1, 4'h3, 10'b10_00_1_1_1_01_0);
        vecs[24] = mk(1, 2'b11, 4'h1, 4'h3, 10'b10_00_1_0_1_01_0);
        vecs[25] = mk(1, 2'b11, 4'h1, 4'h3, 10'b10_00_1_0_1_01_0);
        vecs[26] = mk(1, 2'b11, 4'h1, 4'h3, 10'b10_00_1_0_1_01_0);
        vecs[27] = mk(1, 2'b00, 4'h1, 4'h3, 10'b10_10_1_0_1_10_0);
        vecs[28] = mk(1, 2'b00, 4'h1, 4'h3, 10'b00_00_0_0_1_10_0);

        // Reset, single request, simultaneous requests with back-to-back service
        for (int i = 0; i < 29; i++) begin
            rst = vecs[i].rst; req = vecs[i].req; d0 = vecs[i].d0; d1 = vecs[i].d1;
            tick();
            chk($sformatf("vec%0d", i),
                32'({grant, done, busy, cnt_x, cnt_rst, result, result_z}), 32'(vecs[i].exp));
        end

        // Held requests alternate owners; done pulses one cycle to the owner only
        d0 = 4'hB; d1 = 4'h7; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_done(n);
            chk($sformatf("rr%0d_done", k), 32'(done), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_grant", k), 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_result", k), 32'({result, result_z}), 32'(3'b111));
            if (k == 3) req = '0;
            tick();
            chk($sformatf("rr%0d_pulse", k), 32'(done), 32'd0);
        end

        // Reset in the second SHIFT cycle, then a fresh scan
        req = 2'b01; d0 = 4'hB;
        tick(); tick(); tick();
        rst = 1'b0; req = 2'b10; d1 = 4'b0101;
        tick();
        chk("midop_reset", 32'({grant, done, busy, cnt_x, cnt_rst, result, result_z}), 32'd0);
        rst = 1'b1;
        tick();
        chk("after_reset_grant", 32'({grant, busy}), 32'(3'b101));
        wait_done(n);
        chk("after_reset_done", 32'(done), 32'd2);
        chk("after_reset_result", 32'({result, result_z}), 32'(3'b100));
        req = '0;
        tick();

        // Pointer returns to 0 on reset even after requester 0 was last granted
        req = 2'b01;
        tick(); tick(); tick();
        rst = 1'b0; req = 2'b11;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_ptr_grant", 32'(grant), 32'd1);
        wait_done(n);
        chk("rst_ptr_done", 32'(done), 32'd1);
        req = '0;
        tick();

        // W=8 instance: latency and serial stream, with and without early stop
        d8 = 8'h07; rst8 = 1'b1; req8 = 2'b01;
        n = 0; xs = '0;
        do begin
            tick();
            n++;
            if (n >= 2 && n <= 5) xs[n-2] = cnt_x8;
        end while (done8 == '0 && n < 40);
        chk("w8_len", 32'(n), EARLY ? 32'd7 : 32'd11);
        chk("w8_xseq", 32'(xs), 32'(4'b0111));
        chk("w8_done", 32'(done8), 32'd1);
        chk("w8_result", 32'({result8, result_z8}), 32'(3'b111));
        d8 = 8'hFF;
        n = 0;
        do begin
            tick();
            n++;
        end while (done8 == '0 && n < 40);
        chk("w8ff_len", 32'(n), 32'(exp_shift(8'hFF, W8) + 4));
        chk("w8ff_result", 32'(result8), 32'(exp_result(8'hFF)));
        chk("w8ff_z", 32'(result_z8), (exp_result(8'hFF) == 3) ? 32'd1 : 32'd0);
        req8 = '0;
        tick();

        // Randomized operations against the reference model
        rst = 1'b0; req = '0;
        tick(); tick();
        rst = 1'b1;
        m_ptr = 0;
        for (int it = 0; it < 60; it++) begin
            nidle = $urandom_range(0, 2);
            repeat (nidle) tick();
            mask = 2'($urandom_range(1, 3));
            d0 = 4'($urandom); d1 = 4'($urandom);
            req = mask;
            owner = rr_pick(mask, m_ptr);
            m_ptr = (owner + 1) % N;
            w = (owner == 0) ? d0 : d1;
            elen = exp_shift({4'b0, w}, W) + 3;
            drop = ($urandom_range(0, 3) == 0);
            n = 0;
            do begin
                tick();
                n++;
                if (n == 2 && drop) req = '0;
            end while (done == '0 && n < 40);
            chk($sformatf("rnd%0d_len", it), 32'(n), 32'(elen));
            chk($sformatf("rnd%0d_done", it), 32'(done), 32'(1 << owner));
            chk($sformatf("rnd%0d_grant", it), 32'(grant), 32'(1 << owner));
            chk($sformatf("rnd%0d_result", it), 32'(result), 32'(exp_result({4'b0, w})));
            chk($sformatf("rnd%0d_z", it), 32'(result_z),
                (exp_result({4'b0, w}) == 3) ? 32'd1 : 32'd0);
            req = '0;
            tick();
            chk($sformatf("rnd%0d_idle", it), 32'({busy, done}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
